// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: data width, fetch FSM states and the canonical NOP.
// Used by the fetch stage and the decode/hazard units.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ   = 2'b00,
    S_WAIT  = 2'b01,
    S_FLUSH = 2'b10
  } fetch_state_e;

  // Instruction addresses are always word aligned; the low two bits are dropped.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_hold_buffer.sv
// One-entry skid register that parks a fetched {pc, instr} while decode is stalled.
// Clear wins over load, load wins over unload.
module fetch_hold_buffer
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            load,
  input  logic            unload,
  input  logic [XLEN-1:0] load_pc,
  input  logic [XLEN-1:0] load_instr,
  output logic            valid,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] instr
);

  logic            valid_r;
  logic [XLEN-1:0] pc_r;
  logic [XLEN-1:0] instr_r;

  // Entry storage and occupancy flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_r <= 1'b0;
      pc_r    <= 32'h0000_0000;
      instr_r <= 32'h0000_0000;
    end else if (clear) begin
      valid_r <= 1'b0;
    end else if (load) begin
      valid_r <= 1'b1;
      pc_r    <= load_pc;
      instr_r <= load_instr;
    end else if (unload) begin
      valid_r <= 1'b0;
    end else begin
      valid_r <= valid_r;
    end
  end

  assign valid = valid_r;
  assign pc    = pc_r;
  assign instr = instr_r;

endmodule

// File: rtl/instruction_fetch_unit.sv
// RV32I fetch stage: PC ownership, single-outstanding imem requests, IF/ID register,
// stall hold-off and redirect with discard of the in-flight response.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = riscv_pkg::RESET_PC_DEFAULT,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        if_id_valid,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instruction
);

  riscv_pkg::fetch_state_e state_r;
  riscv_pkg::fetch_state_e state_next_s;

  logic [31:0] pc_r;
  logic [31:0] inflight_pc_r;
  logic        if_id_valid_r;
  logic [31:0] if_id_pc_r;
  logic [31:0] if_id_instr_r;

  logic        req_valid_s;
  logic        handshake_s;
  logic        deliver_s;
  logic        hold_load_s;
  logic        hold_unload_s;
  logic        hold_valid_s;
  logic [31:0] hold_pc_s;
  logic [31:0] hold_instr_s;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= riscv_pkg::S_REQ;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next state; a redirect abandons the in-flight fetch but must still drain its response.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      riscv_pkg::S_REQ: begin
        if (!redirect_valid && handshake_s) state_next_s = riscv_pkg::S_WAIT;
        else                                state_next_s = riscv_pkg::S_REQ;
      end
      riscv_pkg::S_WAIT: begin
        if (imem_resp_valid)     state_next_s = riscv_pkg::S_REQ;
        else if (redirect_valid) state_next_s = riscv_pkg::S_FLUSH;
        else                     state_next_s = riscv_pkg::S_WAIT;
      end
      riscv_pkg::S_FLUSH: begin
        if (imem_resp_valid) state_next_s = riscv_pkg::S_REQ;
        else                 state_next_s = riscv_pkg::S_FLUSH;
      end
      default: state_next_s = riscv_pkg::S_REQ;
    endcase
  end

  // FSM outputs: request issue and response routing strobes.
  always_comb begin
    req_valid_s   = 1'b0;
    deliver_s     = 1'b0;
    if (!rst && (state_r == riscv_pkg::S_REQ) && !stall && !hold_valid_s && !redirect_valid) begin
      req_valid_s = 1'b1;
    end else begin
      req_valid_s = 1'b0;
    end
    if ((state_r == riscv_pkg::S_WAIT) && imem_resp_valid && !redirect_valid) begin
      deliver_s = 1'b1;
    end else begin
      deliver_s = 1'b0;
    end
    handshake_s   = req_valid_s && imem_req_ready;
    hold_load_s   = deliver_s && stall;
    hold_unload_s = hold_valid_s && !stall && !redirect_valid;
  end

  // Program counter and the address of the request awaiting its response.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r          <= RESET_PC;
      inflight_pc_r <= 32'h0000_0000;
    end else if (redirect_valid) begin
      pc_r          <= riscv_pkg::word_align(redirect_pc);
    end else if (handshake_s) begin
      pc_r          <= pc_r + 32'd4;
      inflight_pc_r <= pc_r;
    end else begin
      pc_r          <= pc_r;
    end
  end

  fetch_hold_buffer u_hold (
    .clk        (clk),
    .rst        (rst),
    .clear      (redirect_valid),
    .load       (hold_load_s),
    .unload     (hold_unload_s),
    .load_pc    (inflight_pc_r),
    .load_instr (imem_resp_data),
    .valid      (hold_valid_s),
    .pc         (hold_pc_s),
    .instr      (hold_instr_s)
  );

  // IF/ID register; a parked word always goes ahead of a fresh one (they never coexist).
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id_valid_r <= 1'b0;
      if_id_pc_r    <= 32'h0000_0000;
      if_id_instr_r <= NOP_INSTR;
    end else if (redirect_valid) begin
      if_id_valid_r <= 1'b0;
      if_id_instr_r <= NOP_INSTR;
    end else if (!stall) begin
      if (hold_valid_s) begin
        if_id_valid_r <= 1'b1;
        if_id_pc_r    <= hold_pc_s;
        if_id_instr_r <= hold_instr_s;
      end else if (deliver_s) begin
        if_id_valid_r <= 1'b1;
        if_id_pc_r    <= inflight_pc_r;
        if_id_instr_r <= imem_resp_data;
      end else begin
        if_id_valid_r <= 1'b0;
        if_id_instr_r <= NOP_INSTR;
      end
    end else begin
      if_id_valid_r <= if_id_valid_r;
    end
  end

  assign imem_req_valid    = req_valid_s;
  assign imem_req_addr     = pc_r;
  assign if_id_valid       = if_id_valid_r;
  assign if_id_pc          = if_id_pc_r;
  assign if_id_instruction = if_id_instr_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench: the bench plays instruction memory and predicts the fetched
// instruction stream (sequential PCs, restarted by redirects and resets).
module tb_instruction_fetch_unit;

  localparam logic [31:0] RST_PC = 32'hFFFF_FFF0;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam int          NCYC   = 4000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_pc;
  logic [31:0] if_id_instruction;

  always #5 clk = ~clk;

  instruction_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
    .clk               (clk),
    .rst               (rst),
    .imem_req_valid    (imem_req_valid),
    .imem_req_ready    (imem_req_ready),
    .imem_req_addr     (imem_req_addr),
    .imem_resp_valid   (imem_resp_valid),
    .imem_resp_data    (imem_resp_data),
    .stall             (stall),
    .redirect_valid    (redirect_valid),
    .redirect_pc       (redirect_pc),
    .if_id_valid       (if_id_valid),
    .if_id_pc          (if_id_pc),
    .if_id_instruction (if_id_instruction)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t exp_q[$];
  int tests = 0;
  int fails = 0;
  int delivered = 0;
  // What happened at the last rising edge: 0 reset, 1 redirect, 2 advance, 3 stalled, 4 none yet.
  int edge_kind = 4;

  logic [31:0] fetch_pc;
  bit          mem_busy;
  bit          mem_stale;
  logic [31:0] mem_addr;
  int          mem_delay;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return (addr * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model, stimulus and expected-stream bookkeeping.
  initial begin
    bit          resp_fire;
    bit          exp_req;
    bit          hs;
    logic [31:0] hs_addr;
    rst = 1'b1; imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'd0;
    stall = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'd0;
    fetch_pc = RST_PC; mem_busy = 1'b0; mem_stale = 1'b0; mem_addr = 32'd0; mem_delay = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      #1;
      rst            = (cyc < 3) || ($urandom_range(0, 299) == 0);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFD : $urandom();
      resp_fire = 1'b0;
      if (mem_busy) begin
        if (mem_delay == 0) resp_fire = 1'b1;
        else mem_delay--;
      end
      imem_resp_valid = resp_fire;
      imem_resp_data  = resp_fire ? mem_word(mem_addr) : $urandom();
      #1;
      exp_req = !rst && !stall && !redirect_valid && !mem_busy && (exp_q.size() == 0);
      check("req_valid", {31'd0, imem_req_valid}, {31'd0, exp_req});
      if (imem_req_valid && !rst) check("req_addr", imem_req_addr, fetch_pc);
      hs      = imem_req_valid && imem_req_ready;
      hs_addr = imem_req_addr;
      @(posedge clk);
      if (rst) begin
        exp_q.delete();
        fetch_pc  = RST_PC;
        mem_busy  = 1'b0;
        edge_kind = 0;
      end else begin
        if (resp_fire) begin
          mem_busy = 1'b0;
          if (!redirect_valid && !mem_stale) exp_q.push_back({mem_addr, mem_word(mem_addr)});
        end
        if (redirect_valid) begin
          exp_q.delete();
          mem_stale = 1'b1;
          fetch_pc  = redirect_pc & 32'hFFFF_FFFC;
          edge_kind = 1;
        end else begin
          edge_kind = stall ? 3 : 2;
        end
        if (hs) begin
          mem_busy  = 1'b1;
          mem_stale = 1'b0;
          mem_addr  = hs_addr;
          mem_delay = $urandom_range(0, 3);
          fetch_pc  = fetch_pc + 32'd4;
        end
      end
    end
    @(negedge clk);
    #2;
    tests++;
    if (delivered < 100) begin
      fails++;
      $display("FAIL progress: got %0d delivered instructions expected at least 100", delivered);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  logic        p_valid;
  logic [31:0] p_pc;
  logic [31:0] p_instr;

  // Monitor: compares IF/ID against the expected stream after each rising edge.
  always @(negedge clk) begin
    entry_t e;
    case (edge_kind)
      0: begin
        check("rst_valid", {31'd0, if_id_valid}, 32'd0);
        check("rst_pc", if_id_pc, 32'd0);
        check("rst_instr", if_id_instruction, NOP);
      end
      1: begin
        check("redir_valid", {31'd0, if_id_valid}, 32'd0);
        check("redir_instr", if_id_instruction, NOP);
      end
      2: begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("ifid_valid", {31'd0, if_id_valid}, 32'd1);
          check("ifid_pc", if_id_pc, e.pc);
          check("ifid_instr", if_id_instruction, e.instr);
          delivered <= delivered + 1;
        end else begin
          check("bubble_valid", {31'd0, if_id_valid}, 32'd0);
          check("bubble_instr", if_id_instruction, NOP);
          check("bubble_pc", if_id_pc, p_pc);
        end
      end
      3: begin
        check("stall_valid", {31'd0, if_id_valid}, {31'd0, p_valid});
        check("stall_pc", if_id_pc, p_pc);
        check("stall_instr", if_id_instruction, p_instr);
      end
      default: ;
    endcase
    p_valid <= if_id_valid;
    p_pc    <= if_id_pc;
    p_instr <= if_id_instruction;
  end

endmodule
